// File: rtl/sparse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sparse_pkg
//  Description : Shared widths, FSM state encoding and header-word helper
//                for the sparse row encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package sparse_pkg;

    localparam int VAL_WIDTH  = 8;
    localparam int IDX_WIDTH  = 8;
    localparam int WORD_WIDTH = IDX_WIDTH + VAL_WIDTH;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HDR     = 2'd1,
        EMIT    = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Header word: nonzero count in the index field, zero value field.
    function automatic logic [WORD_WIDTH-1:0] header_word(input logic [IDX_WIDTH-1:0] count);
        return {count, {VAL_WIDTH{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sparse_row_buf.sv
`default_nettype none
// ============================================================================
//  Module      : sparse_row_buf
//  Description : Simple dual-port synchronous RAM, one write port and one
//                registered read port (1-cycle read latency). Not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sparse_row_buf #(
    parameter int DEPTH      = 28,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/sparse_row_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : sparse_row_encoder
//  Description : Buffers one dense pixel row, then emits a header word with
//                the nonzero count followed by {index, value} of each nonzero.
//  Revision    : 1.0 - initial release
// ============================================================================
module sparse_row_encoder
    import sparse_pkg::*;
#(
    parameter int ROW_LENGTH = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [VAL_WIDTH-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_header,
    output logic                  out_last,
    output logic                  row_done
);

    localparam int                   c_AW       = (ROW_LENGTH > 1) ? $clog2(ROW_LENGTH) : 1;
    localparam logic [IDX_WIDTH-1:0] c_LAST_COL = IDX_WIDTH'(ROW_LENGTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_WIDTH-1:0]  r_col;
    logic [IDX_WIDTH-1:0]  r_nz_count;
    logic [IDX_WIDTH-1:0]  r_rd_ptr;
    logic [IDX_WIDTH-1:0]  w_rd_ptr_nxt;
    logic                  w_in_fire;
    logic                  w_wr_en;
    logic                  w_emit_last;
    logic [WORD_WIDTH-1:0] w_rd_data;

    assign w_in_fire   = in_valid && (r_state == COLLECT);
    assign w_wr_en     = w_in_fire && (in_data != '0);
    assign w_emit_last = (r_rd_ptr == (r_nz_count - 1'b1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The read address follows the next rd_ptr so the RAM output already
    // holds the entry to be shown in the coming cycle (no bubbles).
    always_comb begin
        w_state_nxt  = r_state;
        w_rd_ptr_nxt = r_rd_ptr;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_header   = 1'b0;
        out_last     = 1'b0;
        row_done     = 1'b0;
        case (r_state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && (r_col == c_LAST_COL)) begin
                    w_state_nxt = HDR;
                end
            end
            HDR: begin
                out_valid    = 1'b1;
                out_data     = header_word(r_nz_count);
                out_header   = 1'b1;
                out_last     = (r_nz_count == '0);
                w_rd_ptr_nxt = '0;
                if (out_ready) begin
                    w_state_nxt = (r_nz_count == '0) ? DONE : EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = w_rd_data;
                out_last  = w_emit_last;
                if (out_ready) begin
                    if (w_emit_last) begin
                        w_state_nxt  = DONE;
                        w_rd_ptr_nxt = '0;
                    end else begin
                        w_rd_ptr_nxt = r_rd_ptr + 1'b1;
                    end
                end
            end
            DONE: begin
                row_done    = 1'b1;
                w_state_nxt = COLLECT;
            end
            default: begin
                w_state_nxt = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_nz_count <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            if (r_state == DONE) begin
                r_nz_count <= '0;
            end else if (w_wr_en) begin
                r_nz_count <= r_nz_count + 1'b1;
            end
            if (w_in_fire) begin
                r_col <= (r_col == c_LAST_COL) ? '0 : r_col + 1'b1;
            end
        end
    end

    sparse_row_buf #(
        .DEPTH      (ROW_LENGTH),
        .WIDTH      (WORD_WIDTH),
        .ADDR_WIDTH (c_AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (r_nz_count[c_AW-1:0]),
        .wr_data ({r_col, in_data}),
        .rd_addr (w_rd_ptr_nxt[c_AW-1:0]),
        .rd_data (w_rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_sparse_row_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sparse_row_encoder
//  Description : Self-checking bench: directed and random rows compared with
//                a list-based model of the compressed word stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sparse_row_encoder;

    localparam int ROW_LENGTH = 28;

    typedef struct {
        logic [15:0] data;
        logic        hdr;
        logic        last;
        int          cyc;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_header;
    logic        out_last;
    logic        row_done;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    int          pat_idx = 0;
    logic [7:0]  row_pix [ROW_LENGTH];
    word_t       got [$];
    word_t       exp_q [$];

    sparse_row_encoder #(.ROW_LENGTH(ROW_LENGTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_header (out_header),
        .out_last   (out_last),
        .row_done   (row_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // out_ready driver: 0 = always ready, 1 = random, 2 = 1,0,0,1 per offered word
    initial begin
        bit [3:0] pat;
        pat = 4'b1001;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    out_ready = pat[3 - pat_idx];
                    if (out_valid) pat_idx = (pat_idx + 1) % 4;
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: capture accepted words, check stalls, row_done and in_ready
    initial begin
        logic        stall_pending;
        logic [17:0] held;
        logic        prev_acc_last;
        logic        prev_row_done;
        word_t       w;
        stall_pending = 1'b0;
        held          = '0;
        prev_acc_last = 1'b0;
        prev_row_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_pending = 1'b0;
                prev_acc_last = 1'b0;
                prev_row_done = 1'b0;
            end else begin
                chk("row_done_after_last", {31'd0, row_done}, {31'd0, prev_acc_last});
                if (prev_row_done) chk("in_ready_after_done", {31'd0, in_ready}, 32'd1);
                if (stall_pending)
                    chk("stall_hold", {13'd0, out_valid, out_data, out_header, out_last},
                        {13'd0, 1'b1, held});
                if (out_valid || row_done) chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
                if (out_valid && out_ready) begin
                    w.data = out_data;
                    w.hdr  = out_header;
                    w.last = out_last;
                    w.cyc  = cyc;
                    got.push_back(w);
                end
                prev_acc_last = out_valid && out_ready && out_last;
                stall_pending = out_valid && !out_ready;
                held          = {out_data, out_header, out_last};
                prev_row_done = row_done;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // Expected stream: header with nonzero count, then one word per nonzero in column order
    function automatic void model_row();
        int    nz_cols [$];
        word_t w;
        for (int c = 0; c < ROW_LENGTH; c++)
            if (row_pix[c] != 8'h00) nz_cols.push_back(c);
        w.data = {8'(nz_cols.size()), 8'h00};
        w.hdr  = 1'b1;
        w.last = (nz_cols.size() == 0);
        w.cyc  = 0;
        exp_q.push_back(w);
        for (int k = 0; k < nz_cols.size(); k++) begin
            w.data = {8'(nz_cols[k]), row_pix[nz_cols[k]]};
            w.hdr  = 1'b0;
            w.last = (k == nz_cols.size() - 1);
            exp_q.push_back(w);
        end
    endfunction

    task automatic send_pixels(input int n, input bit keep_valid);
        for (int i = 0; i < n; i++) begin
            int wait_cyc;
            bit took;
            wait_cyc = 0;
            took     = 1'b0;
            in_valid = 1'b1;
            in_data  = row_pix[i];
            while (!took) begin
                @(negedge clk);
                took = (in_ready === 1'b1);
                @(posedge clk);
                #1;
                wait_cyc++;
                if (!took && wait_cyc > 1000) begin
                    $display("FAIL in_ready_timeout observed=0 expected=1");
                    $fatal(1, "in_ready never asserted");
                end
            end
        end
        if (!keep_valid) begin
            in_valid = 1'b0;
            in_data  = 8'h00;
        end
        if (n == ROW_LENGTH) chk("hdr_latency", {30'd0, out_valid, out_header}, 32'd3);
    endtask

    task automatic check_words(input string tag, input bit gapless);
        int t;
        int n;
        t = 0;
        while (got.size() < exp_q.size() && t < 4000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, {16'd0, got[i].data}, {16'd0, exp_q[i].data});
            chk({tag, "_flags"}, {30'd0, got[i].hdr, got[i].last},
                {30'd0, exp_q[i].hdr, exp_q[i].last});
            if (gapless && i > 0 && !got[i].hdr)
                chk({tag, "_gap"}, got[i].cyc - got[i-1].cyc, 32'd1);
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic plan_row();
        for (int c = 0; c < ROW_LENGTH; c++) row_pix[c] = 8'h00;
        row_pix[3]  = 8'd5;
        row_pix[10] = 8'd7;
        row_pix[27] = 8'd9;
    endtask

    task automatic random_row();
        int density;
        density = $urandom_range(0, 100);
        for (int c = 0; c < ROW_LENGTH; c++)
            row_pix[c] = ($urandom_range(0, 99) < density) ? 8'($urandom_range(1, 255)) : 8'h00;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_outputs", {12'd0, out_valid, out_data, out_header, out_last, row_done}, 32'd0);

        // Directed sparse row
        plan_row();
        model_row();
        send_pixels(ROW_LENGTH, 1'b0);
        chk("plan_hdr_word", {16'd0, out_data}, 32'h0300);
        check_words("plan", 1'b1);

        // All-zero row followed immediately by another row
        for (int c = 0; c < ROW_LENGTH; c++) row_pix[c] = 8'h00;
        model_row();
        send_pixels(ROW_LENGTH, 1'b0);
        chk("zero_hdr_flags", {14'd0, out_data, out_header, out_last}, {14'd0, 16'h0000, 2'b11});
        check_words("zero", 1'b1);

        // Full row: pixel = col + 1
        for (int c = 0; c < ROW_LENGTH; c++) row_pix[c] = 8'(c + 1);
        model_row();
        send_pixels(ROW_LENGTH, 1'b0);
        chk("full_hdr_word", {16'd0, out_data}, 32'h1C00);
        chk("full_last_word", {16'd0, exp_q[exp_q.size()-1].data}, 32'h1B1C);
        check_words("full", 1'b1);

        // Backpressure pattern on the directed row
        ready_mode = 2;
        pat_idx    = 0;
        plan_row();
        model_row();
        send_pixels(ROW_LENGTH, 1'b0);
        check_words("stall", 1'b0);
        ready_mode = 0;

        // Abort mid-row with reset, then the directed row again
        random_row();
        for (int c = 0; c < 12; c++) row_pix[c] = 8'($urandom_range(1, 255));
        send_pixels(12, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_outputs", {12'd0, out_valid, out_data, out_header, out_last, row_done}, 32'd0);
        plan_row();
        model_row();
        send_pixels(ROW_LENGTH, 1'b0);
        check_words("abort", 1'b1);

        // Back-to-back rows with in_valid held high
        random_row();
        model_row();
        send_pixels(ROW_LENGTH, 1'b1);
        random_row();
        model_row();
        send_pixels(ROW_LENGTH, 1'b0);
        check_words("b2b", 1'b1);

        // Random rows under random backpressure
        ready_mode = 1;
        for (int r = 0; r < 8; r++) begin
            random_row();
            model_row();
            send_pixels(ROW_LENGTH, 1'b0);
            check_words("rand", 1'b0);
        end
        ready_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
